// File: rtl/sl3_tx_pkt_arbiter_pkg.sv
// Shared types for the SL3 user network TX packet arbiter: source ids,
// the user packet beat format and the arbiter FSM encoding.
package sl3_tx_pkt_arbiter_pkg;

  localparam int unsigned TX_SRC_RESULTS = 0;
  localparam int unsigned TX_SRC_INPUT   = 1;
  localparam int unsigned TX_SRC_AUX     = 2;
  localparam int unsigned NUM_TX_SRC     = 3;

  localparam int unsigned USER_DATA_BITS = 32;

  typedef struct packed {
    logic                      valid;
    logic                      last;
    logic [USER_DATA_BITS-1:0] data;
  } UserPacketWord;

  localparam int unsigned USER_WORD_BITS = $bits(UserPacketWord);

  typedef enum logic [0:0] {
    StIdle,
    StLocked
  } arb_state_e;

  function automatic int unsigned wrap_inc(int unsigned v, int unsigned n);
    return (v + 1 >= n) ? 0 : v + 1;
  endfunction

endpackage

// File: rtl/sl3_tx_pkt_arbiter_rr_priority_pick.sv
// Rotating-priority encoder: first set request at or after the start index,
// wrapping modulo N.
module sl3_tx_pkt_arbiter_rr_priority_pick #(
  parameter int unsigned N = 3
) (
  input  logic [N-1:0]         req,
  input  logic [$clog2(N)-1:0] start,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] index,
  output logic                 found
);

  localparam int unsigned IdxW = $clog2(N);

  always_comb begin
    int unsigned j;
    j      = 0;
    onehot = '0;
    index  = '0;
    found  = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      j = 32'(start) + k;
      if (j >= N) j = j - N;
      if (!found && req[j]) begin
        found     = 1'b1;
        index     = IdxW'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/sl3_tx_pkt_arbiter.sv
// Packet-granular weighted round-robin arbiter feeding the SL3 user TX port.
// One source is locked per packet; weights give packets per turn.
module sl3_tx_pkt_arbiter
  import sl3_tx_pkt_arbiter_pkg::*;
#(
  parameter int unsigned NUM_SRC     = 3,
  parameter int unsigned WEIGHT_BITS = 8
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start_core,
  input  logic [NUM_SRC*WEIGHT_BITS-1:0]    src_weight,
  input  logic [NUM_SRC*USER_WORD_BITS-1:0] src_word,
  input  logic [NUM_SRC-1:0]                src_valid,
  output logic [NUM_SRC-1:0]                src_ready,
  output logic [USER_WORD_BITS-1:0]         out_word,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [$clog2(NUM_SRC)-1:0]        grant_src,
  output logic                              busy,
  output logic [NUM_SRC*32-1:0]             src_pkt_count
);

  localparam int unsigned IdxW = $clog2(NUM_SRC);

  arb_state_e             state_q, state_d;
  logic [IdxW-1:0]        cur_q, cur_d;
  logic [IdxW-1:0]        rr_q, rr_d;
  logic [WEIGHT_BITS-1:0] turn_q, turn_d;
  UserPacketWord          out_word_q, out_word_d;
  logic                   out_valid_q, out_valid_d;
  logic [31:0]            cnt_q [NUM_SRC];
  logic [31:0]            cnt_d [NUM_SRC];

  logic [WEIGHT_BITS-1:0] weight [NUM_SRC];
  UserPacketWord          word   [NUM_SRC];
  logic [NUM_SRC-1:0]     req;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_unpack
    assign weight[g] = src_weight[g*WEIGHT_BITS +: WEIGHT_BITS];
    assign word[g]   = src_word[g*USER_WORD_BITS +: USER_WORD_BITS];
    assign req[g]    = src_valid[g] & (weight[g] != '0);
    assign src_pkt_count[g*32 +: 32] = cnt_q[g];
  end

  logic [NUM_SRC-1:0] pick_onehot;
  logic [IdxW-1:0]    pick_idx;
  logic               pick_found;

  sl3_tx_pkt_arbiter_rr_priority_pick #(
    .N (NUM_SRC)
  ) u_pick (
    .req    (req),
    .start  (rr_q),
    .onehot (pick_onehot),
    .index  (pick_idx),
    .found  (pick_found)
  );

  logic [IdxW-1:0]        grant;
  logic                   eligible;
  logic                   can_take;
  logic                   accept;
  UserPacketWord          acc_word;
  logic [WEIGHT_BITS-1:0] turn_eff;
  logic [WEIGHT_BITS:0]   turn_next;

  always_comb begin
    state_d     = state_q;
    cur_d       = cur_q;
    rr_d        = rr_q;
    turn_d      = turn_q;
    out_word_d  = out_word_q;
    out_valid_d = out_valid_q;
    cnt_d       = cnt_q;
    grant       = cur_q;
    eligible    = 1'b0;
    turn_eff    = turn_q;
    turn_next   = '0;
    src_ready   = '0;

    if (state_q == StIdle) begin
      grant    = pick_idx;
      eligible = pick_found;
      // A new winner starts a fresh turn; this must also hold for a 1-beat
      // packet that ends in this same cycle.
      if (pick_found && (pick_idx != cur_q)) begin
        cur_d    = pick_idx;
        turn_eff = '0;
        turn_d   = '0;
      end
    end else begin
      eligible = src_valid[cur_q];
    end

    can_take = ~out_valid_q | out_ready;
    accept   = eligible & can_take;
    acc_word = word[grant];

    if (accept) begin
      src_ready   = (state_q == StIdle) ? pick_onehot : (NUM_SRC'(1) << cur_q);
      out_word_d  = acc_word;
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end

    if (accept && acc_word.last) begin
      cnt_d[grant] = cnt_q[grant] + 32'd1;
      turn_next    = {1'b0, turn_eff} + (WEIGHT_BITS+1)'(1);
      if (turn_next >= {1'b0, weight[grant]}) begin
        rr_d   = IdxW'(wrap_inc(32'(grant), NUM_SRC));
        turn_d = '0;
      end else begin
        rr_d   = grant;
        turn_d = turn_next[WEIGHT_BITS-1:0];
      end
    end

    unique case (state_q)
      StIdle:   if (accept && !acc_word.last) state_d = StLocked;
      StLocked: if (accept && acc_word.last) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n || start_core) begin
      state_q     <= StIdle;
      cur_q       <= '0;
      rr_q        <= '0;
      turn_q      <= '0;
      out_word_q  <= '0;
      out_valid_q <= 1'b0;
      for (int i = 0; i < NUM_SRC; i++) cnt_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      cur_q       <= cur_d;
      rr_q        <= rr_d;
      turn_q      <= turn_d;
      out_word_q  <= out_word_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  always_comb begin
    UserPacketWord w;
    w        = out_word_q;
    w.valid  = out_valid_q;
    out_word = w;
  end

  assign out_valid = out_valid_q;
  assign grant_src = cur_q;
  assign busy      = (state_q == StLocked);

endmodule

// File: tb/tb_sl3_tx_pkt_arbiter.sv
// Directed bench for sl3_tx_pkt_arbiter: cycle vector table plus packet-level
// sequences checked against an expected source order.
module tb_sl3_tx_pkt_arbiter;
  import sl3_tx_pkt_arbiter_pkg::*;

  localparam int NS = 3;
  localparam int WB = 8;
  localparam int UW = USER_WORD_BITS;

  logic              clk = 1'b0;
  logic              rst_n, start_core, out_ready, out_valid, busy;
  logic [NS*WB-1:0]  src_weight;
  logic [NS*UW-1:0]  src_word;
  logic [NS-1:0]     src_valid, src_ready;
  logic [UW-1:0]     out_word;
  logic [1:0]        grant_src;
  logic [NS*32-1:0]  src_pkt_count;

  always #5 clk = ~clk;

  sl3_tx_pkt_arbiter #(
    .NUM_SRC     (NS),
    .WEIGHT_BITS (WB)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start_core    (start_core),
    .src_weight    (src_weight),
    .src_word      (src_word),
    .src_valid     (src_valid),
    .src_ready     (src_ready),
    .out_word      (out_word),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .grant_src     (grant_src),
    .busy          (busy),
    .src_pkt_count (src_pkt_count)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // Source model: each source emits packets of len[s] beats while enabled.
  bit en  [NS];
  int len [NS];
  int bidx[NS];
  int pnum[NS];
  // Output scoreboard: expected order of packet sources.
  int exp_src[$];
  int exp_pnum[NS];
  int obidx;
  bit prev_stall;
  logic [UW-1:0] prev_word;
  bit chk_bub, saw_out;
  int bubbles;
  int rdy2_hits;

  function automatic logic [31:0] beat_data(int s, int p, int b);
    return {4'(s), 12'(p), 16'(b)};
  endfunction

  task automatic set_w(int w0, int w1, int w2);
    src_weight = {8'(w2), 8'(w1), 8'(w0)};
  endtask

  task automatic model_reset();
    for (int s = 0; s < NS; s++) begin
      en[s] = 1'b0; len[s] = 4; bidx[s] = 0; pnum[s] = 0; exp_pnum[s] = 0;
    end
    exp_src.delete();
    obidx = 0; prev_stall = 1'b0; chk_bub = 1'b0; saw_out = 1'b0;
    bubbles = 0; rdy2_hits = 0;
  endtask

  task automatic apply_src();
    UserPacketWord w;
    for (int s = 0; s < NS; s++) begin
      w.valid = 1'b0;
      w.last  = (bidx[s] == len[s] - 1);
      w.data  = beat_data(s, pnum[s], bidx[s]);
      src_word[s*UW +: UW] = w;
      src_valid[s] = en[s];
    end
  endtask

  task automatic check_out();
    UserPacketWord w;
    int s;
    w = out_word;
    if (prev_stall) chk("stall_hold", out_word, prev_word);
    if (out_valid) chk("valid_field", w.valid, 1'b1);
    if (out_valid && !out_ready) chk("stall_rdy", src_ready, 3'b000);
    if (src_ready[2]) rdy2_hits++;
    if (out_valid) saw_out = 1'b1;
    if (chk_bub && saw_out && !out_valid && exp_src.size() != 0) bubbles++;
    if (out_valid && out_ready && exp_src.size() != 0) begin
      s = exp_src[0];
      chk("beat_data", w.data, beat_data(s, exp_pnum[s], obidx));
      chk("beat_last", w.last, obidx == len[s] - 1);
      if (obidx == len[s] - 1) begin
        void'(exp_src.pop_front());
        exp_pnum[s]++;
        obidx = 0;
      end else begin
        obidx++;
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_word  = out_word;
  endtask

  task automatic tick();
    bit acc[NS];
    apply_src();
    @(negedge clk);
    check_out();
    for (int s = 0; s < NS; s++) acc[s] = src_valid[s] && src_ready[s];
    @(posedge clk);
    #1;
    for (int s = 0; s < NS; s++) begin
      if (acc[s]) begin
        if (bidx[s] == len[s] - 1) begin
          bidx[s] = 0;
          pnum[s]++;
        end else begin
          bidx[s]++;
        end
      end
    end
  endtask

  task automatic run_until_done(string name, int budget);
    int n = 0;
    while (exp_src.size() != 0 && n < budget) begin
      tick();
      n++;
    end
    chk(name, exp_src.size(), 0);
  endtask

  task automatic check_cleared(string name);
    chk({name, "_ov"}, out_valid, 1'b0);
    chk({name, "_busy"}, busy, 1'b0);
    chk({name, "_grant"}, grant_src, 2'd0);
    chk({name, "_cnt"}, src_pkt_count, '0);
  endtask

  task automatic soft_clear();
    for (int s = 0; s < NS; s++) en[s] = 1'b0;
    apply_src();
    out_ready  = 1'b1;
    start_core = 1'b1;
    @(posedge clk);
    #1;
    start_core = 1'b0;
    check_cleared("clear");
    model_reset();
  endtask

  typedef struct {
    logic [2:0] vld;
    logic [2:0] lst;
    logic       ordy;
    logic [2:0] rdy;
    logic       ov;
    logic       bsy;
    logic [1:0] gnt;
  } vec_t;

  vec_t vt[11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    UserPacketWord w;
    vt[0]  = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 2'd0};
    vt[1]  = '{3'b011, 3'b000, 1'b1, 3'b001, 1'b0, 1'b0, 2'd0};
    vt[2]  = '{3'b011, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 2'd0};
    vt[3]  = '{3'b011, 3'b010, 1'b1, 3'b010, 1'b1, 1'b0, 2'd0};
    vt[4]  = '{3'b011, 3'b000, 1'b0, 3'b000, 1'b1, 1'b0, 2'd1};
    vt[5]  = '{3'b011, 3'b000, 1'b1, 3'b001, 1'b1, 1'b0, 2'd0};
    vt[6]  = '{3'b010, 3'b000, 1'b1, 3'b000, 1'b1, 1'b1, 2'd0};
    vt[7]  = '{3'b011, 3'b001, 1'b1, 3'b001, 1'b0, 1'b1, 2'd0};
    vt[8]  = '{3'b100, 3'b100, 1'b1, 3'b100, 1'b1, 1'b0, 2'd0};
    vt[9]  = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b1, 1'b0, 2'd2};
    vt[10] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 2'd2};

    model_reset();
    rst_n = 1'b0; start_core = 1'b0; out_ready = 1'b1;
    set_w(1, 1, 1);
    apply_src();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_cleared("reset");
    chk("reset_rdy", src_ready, 3'b000);

    // Cycle-level vectors: handshakes, gaps, stalls and 1-beat packets.
    for (int k = 0; k < 11; k++) begin
      for (int s = 0; s < NS; s++) begin
        w.valid = 1'b1;
        w.last  = vt[k].lst[s];
        w.data  = beat_data(s, k, 0);
        src_word[s*UW +: UW] = w;
      end
      src_valid = vt[k].vld;
      out_ready = vt[k].ordy;
      @(negedge clk);
      chk($sformatf("v%0d_rdy", k), src_ready, vt[k].rdy);
      chk($sformatf("v%0d_ov", k), out_valid, vt[k].ov);
      chk($sformatf("v%0d_busy", k), busy, vt[k].bsy);
      chk($sformatf("v%0d_gnt", k), grant_src, vt[k].gnt);
      @(posedge clk);
      #1;
    end
    chk("vec_cnt0", src_pkt_count[31:0], 2);
    chk("vec_cnt1", src_pkt_count[63:32], 1);
    chk("vec_cnt2", src_pkt_count[95:64], 1);
    soft_clear();

    // Equal weights: strict rotation with no bubbles.
    set_w(1, 1, 1);
    for (int s = 0; s < NS; s++) en[s] = 1'b1;
    exp_src = '{0, 1, 2, 0, 1, 2};
    chk_bub = 1'b1;
    run_until_done("rr111_done", 60);
    chk("rr111_bubbles", bubbles, 0);
    soft_clear();

    // Weighted 3:1 with a disabled source.
    set_w(3, 1, 0);
    for (int s = 0; s < NS; s++) begin
      en[s] = 1'b1; len[s] = 2;
    end
    exp_src = '{0, 0, 0, 1, 0, 0, 0, 1};
    chk_bub = 1'b1;
    run_until_done("w310_done", 60);
    chk("w310_bubbles", bubbles, 0);
    chk("w310_rdy2", rdy2_hits, 0);
    chk("w310_cnt2", src_pkt_count[95:64], 0);
    soft_clear();

    // Weight dropped to 0 mid-packet must not truncate the locked packet.
    set_w(1, 1, 1);
    en[1] = 1'b1; len[1] = 16; len[0] = 4;
    exp_src = '{1, 0, 0};
    repeat (4) tick();
    chk("lock_busy", busy, 1'b1);
    chk("lock_grant", grant_src, 2'd1);
    en[0] = 1'b1;
    set_w(1, 0, 1);
    run_until_done("lock_done", 80);
    soft_clear();

    // Backpressure pattern: order and data kept, word held while stalled.
    set_w(1, 1, 1);
    for (int s = 0; s < NS; s++) en[s] = 1'b1;
    exp_src = '{0, 1, 2, 0, 1, 2};
    begin
      bit pat[4];
      int n;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1};
      n = 0;
      while (exp_src.size() != 0 && n < 300) begin
        out_ready = ((n % 8) < 4) ? pat[n % 4] : 1'($urandom_range(0, 1));
        tick();
        n++;
      end
      chk("bp_done", exp_src.size(), 0);
    end
    soft_clear();

    // Single source, 1-beat packets: one packet per cycle.
    set_w(1, 1, 2);
    en[2] = 1'b1; len[2] = 1;
    exp_src = '{2, 2, 2, 2, 2, 2};
    chk_bub = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      tick();
      chk($sformatf("one_cnt%0d", k), src_pkt_count[95:64], k);
      chk($sformatf("one_gnt%0d", k), grant_src, 2'd2);
    end
    en[2] = 1'b0;
    run_until_done("one_done", 10);
    chk("one_bubbles", bubbles, 0);

    // Hard reset in the middle of a packet, then a clean restart.
    do begin
      model_reset();
      set_w(1, 1, 1);
      en[0] = 1'b1; len[0] = 8;
      exp_src = '{0};
      repeat (3) tick();
      chk("mid_busy", busy, 1'b1);
      en[0] = 1'b0;
      apply_src();
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      check_cleared("midrst");
      model_reset();
      en[0] = 1'b1; len[0] = 8;
      exp_src = '{0};
      run_until_done("restart_done", 30);
      chk("restart_cnt0", src_pkt_count[31:0], 1);
    end while (0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sl3_tx_pkt_arbiter.md
# sl3_tx_pkt_arbiter

Packet-granularity weighted round-robin arbiter that shares the SL3 user network TX port between NUM_SRC packet-formed streams (results, input trees/data, future sources). Each source delivers UserPacketWord beats already framed with `last`; the arbiter grants one source per packet, never interleaves beats of different packets, and enforces software-programmed per-source weights (packets per turn). It sits between the per-source packet FIFOs and the network TX FIFO, replacing fixed two-way alternation.

## Interface
- NUM_SRC, 3, number of requesting streams (2..8)
- WEIGHT_BITS, 8, width of per-source weight
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start_core  in  1  synchronous soft clear (same effect as reset on all state and counters)
- src_weight  in  NUM_SRC x WEIGHT_BITS  packets per turn for each source; 0 = source disabled
- src_word  in  NUM_SRC x $bits(UserPacketWord)  beat from each source (`.valid` field ignored)
- src_valid  in  NUM_SRC  beat present
- src_ready  out  NUM_SRC  beat accepted when src_valid & src_ready
- out_word  out  $bits(UserPacketWord)  registered output beat; `.valid` equals out_valid
- out_valid  out  1  output beat present
- out_ready  in  1  downstream accepts when out_valid & out_ready
- grant_src  out  $clog2(NUM_SRC)  source currently locked (valid when busy)
- busy  out  1  a packet is in progress
- src_pkt_count  out  NUM_SRC x 32  packets forwarded per source (counted on accepted `last`)

## Operation
- States: IDLE, LOCKED.
- IDLE: rotating priority search starting at rr_ptr over sources with src_valid=1 and src_weight!=0; winner s becomes grant combinationally, so its first beat may be accepted in the same cycle. If s != cur_src, turn_cnt <= 0 and cur_src <= s. Accepted non-last beat -> LOCKED. Accepted last beat (1-beat packet) -> packet-end processing, stay IDLE. No eligible source -> stay IDLE, src_ready all 0.
- LOCKED: only src_ready[cur_src] may be 1; other sources stalled regardless of weight/valid. Gaps in src_valid of cur_src hold the lock. Accepted last beat -> packet-end processing, -> IDLE.
- Packet end: src_pkt_count[cur_src]++ (wraps at 2^32); turn_cnt++; if turn_cnt+1 >= src_weight[cur_src] then rr_ptr <= cur_src+1 (mod NUM_SRC), turn_cnt <= 0; else rr_ptr <= cur_src (same source keeps priority).
- Weights sampled only in IDLE selection and at packet end; a weight change or set to 0 during LOCKED never truncates the current packet.
- src_ready[i] = (i==grant) & eligible & (~out_valid | out_ready).
- Output register loads src_word of granted source on accept, out_valid <= 1; clears when out_ready & no new accept.

## Timing
- Latency: 1 cycle src accept -> out_valid. Full throughput (1 beat/cycle) under out_ready=1, including back-to-back packets from the same or different sources (no bubble between packets).
- out_ready=0 with out_valid=1: out_word held stable, src_ready all 0.
- Reset/start_core (mid-packet included): state IDLE, out_valid=0, src_ready=0, busy=0, grant_src=0, rr_ptr=0, turn_cnt=0, cur_src=0, all src_pkt_count=0; in-flight output beat discarded.
- busy=1 in LOCKED, 0 in IDLE.

## Structure
- DTEngine_Types: TX_SRC_RESULTS=0, TX_SRC_INPUT=1, TX_SRC_AUX=2, NUM_TX_SRC; UserPacketWord stays in NetTypes.
- Sub-module rr_priority_pick: combinational rotating-priority encoder (req vector, start pointer -> one-hot/index + found).

## Test plan
- Weights {1,1,1}, all sources continuously offer 4-beat packets -> output source order 0,1,2,0,1,2; beats of a packet contiguous; 1 beat/cycle.
- Weights {3,1,0}, sources 0,1 continuously valid, source 2 valid -> order 0,0,0,1,0,0,0,1; source 2 never granted, src_pkt_count[2]=0.
- Locked on source 1 mid 16-beat packet, source 0 asserts valid and src_weight[1] set to 0 -> all 16 beats of source 1 complete before source 0 granted.
- out_ready toggled 1,0,0,1 random pattern during 4-beat packets -> no beat lost/duplicated, out_word stable while stalled, order preserved.
- Only source 2 valid with 1-beat packets, weight 2 -> one packet per cycle, src_pkt_count[2] increments each cycle, grant_src=2.
- rst_n=0 for one cycle mid packet -> next cycle out_valid=0, busy=0, counters 0; new packet from source 0 restarts cleanly.
